// File: rtl/lsu_stage.sv
// lsu_stage: single-outstanding load/store unit downstream of the ALU.
// Issues one word-wide request/acknowledge bus transaction per command and
// returns sign/zero-extended load data for register writeback.
// Optional: define LSU_TIMEOUT_EN to abort a transaction after TIMEOUT WAIT
// cycles without MEM_ACK (ERR pulse, no LD_WE).
module lsu_stage #(
    parameter int TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        N_RST,
    input  logic [5:0]  LSU_OP,
    input  logic [31:0] O,
    input  logic [31:0] D,
    output logic        BUSY,
    output logic [31:0] LD_DATA,
    output logic        LD_WE,
    output logic        ERR,
    output logic        MEM_REQ,
    output logic        MEM_WE,
    output logic [29:0] MEM_ADDR,
    output logic [3:0]  MEM_BE,
    output logic [31:0] MEM_WDATA,
    input  logic [31:0] MEM_RDATA,
    input  logic        MEM_ACK
);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

    state_t      state_r;
    state_t      state_nxt_s;

    logic        cmd_s;
    logic        is_store_s;
    logic        illegal_s;
    logic        accept_s;
    logic        done_s;
    logic        timeout_s;
    logic [1:0]  size_s;
    logic [3:0]  be_s;
    logic [31:0] wdata_s;

    logic        req_r;
    logic        we_r;
    logic [29:0] addr_r;
    logic [3:0]  be_r;
    logic [31:0] wdata_r;
    logic [1:0]  size_r;
    logic        sign_r;
    logic [1:0]  off_r;
    logic [31:0] ld_data_r;
    logic        ld_we_r;
    logic        err_r;

    logic        req_nxt_s;
    logic        ld_we_nxt_s;
    logic        err_nxt_s;

    // LSU_OP[5] is reserved and deliberately has no effect.
    logic        unused_s;
    assign unused_s = ^{LSU_OP[5], TIMEOUT};

    // Select the addressed lane of a read word and extend it to 32 bits.
    function automatic logic [31:0] extend_load(input logic [31:0] rdata,
                                                input logic [1:0]  size,
                                                input logic [1:0]  off,
                                                input logic        sign);
        logic [31:0] lane;
        logic [31:0] res;
        lane = rdata >> {off, 3'b000};
        case (size)
            2'b00:   res = {{24{sign & lane[7]}}, lane[7:0]};
            2'b01:   res = {{16{sign & lane[15]}}, lane[15:0]};
            default: res = rdata;
        endcase
        return res;
    endfunction

    assign size_s     = LSU_OP[3:2];
    assign cmd_s      = (LSU_OP[1:0] != 2'b00);
    assign is_store_s = (LSU_OP[1:0] == 2'b10);
    assign accept_s   = (state_r == ST_IDLE) && cmd_s && !illegal_s;
    assign done_s     = (state_r == ST_WAIT) && MEM_ACK;

    // Decode command legality, byte enables and replicated write data.
    always_comb begin
        be_s      = 4'b0000;
        wdata_s   = 32'h0000_0000;
        illegal_s = (LSU_OP[1:0] == 2'b11);
        case (size_s)
            2'b00: begin
                be_s    = 4'b0001 << O[1:0];
                wdata_s = {4{D[7:0]}};
            end
            2'b01: begin
                be_s      = O[1] ? 4'b1100 : 4'b0011;
                wdata_s   = {2{D[15:0]}};
                illegal_s = illegal_s | O[0];
            end
            2'b10: begin
                be_s      = 4'b1111;
                wdata_s   = D;
                illegal_s = illegal_s | (O[1:0] != 2'b00);
            end
            default: begin
                illegal_s = 1'b1;
            end
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);
    logic [31:0] cnt_r;

    // Count WAIT cycles; restarted whenever a transaction is launched.
    always_ff @(posedge CLK or negedge N_RST) begin
        if (!N_RST) begin
            cnt_r <= 32'd0;
        end else if (accept_s) begin
            cnt_r <= 32'd0;
        end else if (state_r == ST_WAIT) begin
            cnt_r <= cnt_r + 32'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // An acknowledge on the expiry edge still completes normally.
    assign timeout_s = (state_r == ST_WAIT) && !MEM_ACK && (cnt_r == TO_LAST);
`else
    assign timeout_s = 1'b0;
`endif

    // State register.
    always_ff @(posedge CLK or negedge N_RST) begin
        if (!N_RST) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (done_s || timeout_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Next values of the registered handshake and status outputs.
    always_comb begin
        req_nxt_s   = req_r;
        ld_we_nxt_s = 1'b0;
        err_nxt_s   = 1'b0;
        if (accept_s) begin
            req_nxt_s = 1'b1;
        end else if (done_s || timeout_s) begin
            req_nxt_s = 1'b0;
        end else begin
            req_nxt_s = req_r;
        end
        ld_we_nxt_s = done_s && !we_r;
        err_nxt_s   = ((state_r == ST_IDLE) && cmd_s && illegal_s) || timeout_s;
    end

    // Output and transaction-context registers.
    always_ff @(posedge CLK or negedge N_RST) begin
        if (!N_RST) begin
            req_r     <= 1'b0;
            we_r      <= 1'b0;
            addr_r    <= 30'd0;
            be_r      <= 4'b0000;
            wdata_r   <= 32'h0000_0000;
            size_r    <= 2'b00;
            sign_r    <= 1'b0;
            off_r     <= 2'b00;
            ld_data_r <= 32'h0000_0000;
            ld_we_r   <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            req_r   <= req_nxt_s;
            ld_we_r <= ld_we_nxt_s;
            err_r   <= err_nxt_s;
            if (accept_s) begin
                we_r    <= is_store_s;
                addr_r  <= O[31:2];
                be_r    <= be_s;
                wdata_r <= wdata_s;
                size_r  <= size_s;
                sign_r  <= LSU_OP[4];
                off_r   <= O[1:0];
            end
            if (ld_we_nxt_s) begin
                ld_data_r <= extend_load(MEM_RDATA, size_r, off_r, sign_r);
            end
        end
    end

    assign BUSY      = req_r;
    assign MEM_REQ   = req_r;
    assign MEM_WE    = we_r;
    assign MEM_ADDR  = addr_r;
    assign MEM_BE    = be_r;
    assign MEM_WDATA = wdata_r;
    assign LD_DATA   = ld_data_r;
    assign LD_WE     = ld_we_r;
    assign ERR       = err_r;

endmodule

// File: tb/tb_lsu_stage.sv
// Self-checking bench for lsu_stage: vector table plus hand-written reset,
// idle-acknowledge and (with LSU_TIMEOUT_EN) timeout sequences.
module tb_lsu_stage;

    localparam int K_OK  = 0;
    localparam int K_ERR = 1;
    localparam int K_NOP = 2;

    logic        CLK;
    logic        N_RST;
    logic [5:0]  LSU_OP;
    logic [31:0] O;
    logic [31:0] D;
    logic        BUSY;
    logic [31:0] LD_DATA;
    logic        LD_WE;
    logic        ERR;
    logic        MEM_REQ;
    logic        MEM_WE;
    logic [29:0] MEM_ADDR;
    logic [3:0]  MEM_BE;
    logic [31:0] MEM_WDATA;
    logic [31:0] MEM_RDATA;
    logic        MEM_ACK;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] o;
        logic [31:0] d;
        logic [31:0] rdata;
        int          dly;
        int          kind;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] ld;
    } vec_t;

    typedef struct {
        logic [29:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        logic        chk_wd;
    } bus_t;

    vec_t        vtab[$];
    bus_t        bus_q[$];
    logic [31:0] ld_q[$];
    int          err_pending = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] last_ld = 32'h0;

    lsu_stage #(.TIMEOUT(4)) dut (
        .CLK       (CLK),
        .N_RST     (N_RST),
        .LSU_OP    (LSU_OP),
        .O         (O),
        .D         (D),
        .BUSY      (BUSY),
        .LD_DATA   (LD_DATA),
        .LD_WE     (LD_WE),
        .ERR       (ERR),
        .MEM_REQ   (MEM_REQ),
        .MEM_WE    (MEM_WE),
        .MEM_ADDR  (MEM_ADDR),
        .MEM_BE    (MEM_BE),
        .MEM_WDATA (MEM_WDATA),
        .MEM_RDATA (MEM_RDATA),
        .MEM_ACK   (MEM_ACK)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard side: bus fields at the acknowledge, load data at LD_WE, ERR pulses.
    always @(negedge CLK) begin
        bus_t b;
        if (N_RST && MEM_REQ && MEM_ACK) begin
            if (bus_q.size() == 0) begin
                check("bus_unexpected", 32'(MEM_ADDR), 32'hFFFF_FFFF);
            end else begin
                b = bus_q.pop_front();
                check("bus_addr", 32'(MEM_ADDR), 32'(b.addr));
                check("bus_be", 32'(MEM_BE), 32'(b.be));
                check("bus_we", 32'(MEM_WE), 32'(b.we));
                if (b.chk_wd) check("bus_wdata", MEM_WDATA, b.wdata);
            end
        end
        if (LD_WE) begin
            if (ld_q.size() == 0) begin
                check("ld_we_unexpected", 32'(LD_WE), 32'h0);
            end else begin
                check("ld_data", LD_DATA, ld_q.pop_front());
            end
        end
        if (ERR) begin
            check("err_expected", 32'(err_pending > 0), 32'h1);
            if (err_pending > 0) err_pending--;
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(BUSY), 32'h0);
        check({tag, "_ld_data"}, LD_DATA, 32'h0);
        check({tag, "_ld_we"}, 32'(LD_WE), 32'h0);
        check({tag, "_err"}, 32'(ERR), 32'h0);
        check({tag, "_req"}, 32'(MEM_REQ), 32'h0);
        check({tag, "_we"}, 32'(MEM_WE), 32'h0);
        check({tag, "_addr"}, 32'(MEM_ADDR), 32'h0);
        check({tag, "_be"}, 32'(MEM_BE), 32'h0);
        check({tag, "_wdata"}, MEM_WDATA, 32'h0);
    endtask

    // Apply one vector; entered and left #1 after a rising edge.
    task automatic run_vec(input vec_t v);
        bus_t b;
        logic is_ld;
        is_ld = (v.op[1:0] == 2'b01);
        LSU_OP = v.op;
        O = v.o;
        D = v.d;
        if (v.kind == K_OK) begin
            b.addr = v.o[31:2];
            b.be = v.be;
            b.we = (v.op[1:0] == 2'b10);
            b.wdata = v.wdata;
            b.chk_wd = b.we;
            bus_q.push_back(b);
            if (is_ld) ld_q.push_back(v.ld);
        end
        if (v.kind == K_ERR) err_pending++;
        @(posedge CLK); #1;
        if (v.kind == K_ERR) begin
            LSU_OP = 6'h00;
            check("err_pulse", 32'(ERR), 32'h1);
            check("err_busy", 32'(BUSY), 32'h0);
            check("err_req", 32'(MEM_REQ), 32'h0);
            @(posedge CLK); #1;
            check("err_clear", 32'(ERR), 32'h0);
            check("err_req2", 32'(MEM_REQ), 32'h0);
        end else if (v.kind == K_NOP) begin
            check("nop_busy", 32'(BUSY), 32'h0);
            check("nop_err", 32'(ERR), 32'h0);
        end else begin
            // The pipeline may present anything while BUSY; it must be ignored.
            LSU_OP = 6'(($urandom % 2) + 1);
            O = $urandom;
            D = $urandom;
            check("busy_rise", 32'(BUSY), 32'h1);
            check("req_rise", 32'(MEM_REQ), 32'h1);
            for (int i = 0; i < v.dly; i++) begin
                @(posedge CLK); #1;
                check("busy_hold", 32'(BUSY), 32'h1);
            end
            MEM_ACK = 1'b1;
            MEM_RDATA = v.rdata;
            @(posedge CLK); #1;
            MEM_ACK = 1'b0;
            MEM_RDATA = $urandom;
            LSU_OP = 6'h00;
            check("busy_fall", 32'(BUSY), 32'h0);
            check("req_fall", 32'(MEM_REQ), 32'h0);
            check("ld_we_pulse", 32'(LD_WE), 32'(is_ld));
            if (is_ld) last_ld = v.ld;
            else check("ld_data_hold", LD_DATA, last_ld);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        N_RST = 1'b0;
        LSU_OP = 6'h00;
        O = 32'h0;
        D = 32'h0;
        MEM_RDATA = 32'h0;
        MEM_ACK = 1'b0;

        //            op          o             d             rdata        dly kind   be       wdata         ld
        vtab.push_back('{6'b001010, 32'h0000_0104, 32'hDEAD_BEEF, 32'h0,        2, K_OK,  4'b1111, 32'hDEAD_BEEF, 32'h0});
        vtab.push_back('{6'b010001, 32'h0000_0203, 32'h0,         32'h8011_2233, 0, K_OK,  4'b1000, 32'h0,         32'hFFFF_FF80});
        vtab.push_back('{6'b100001, 32'h0000_0203, 32'h0,         32'h8011_2233, 0, K_OK,  4'b1000, 32'h0,         32'h0000_0080});
        vtab.push_back('{6'b000101, 32'h0000_0002, 32'h0,         32'hABCD_1234, 1, K_OK,  4'b1100, 32'h0,         32'h0000_ABCD});
        vtab.push_back('{6'b000110, 32'h0000_0002, 32'h0000_5678, 32'h0,        0, K_OK,  4'b1100, 32'h5678_5678, 32'h0});
        vtab.push_back('{6'b010101, 32'h0000_0010, 32'h0,         32'h1234_8001, 1, K_OK,  4'b0011, 32'h0,         32'hFFFF_8001});
        vtab.push_back('{6'b000010, 32'h0000_0031, 32'h1234_56A5, 32'h0,        0, K_OK,  4'b0010, 32'hA5A5_A5A5, 32'h0});
        vtab.push_back('{6'b011001, 32'h0000_0010, 32'h0,         32'hCAFE_F00D, 3, K_OK,  4'b1111, 32'h0,         32'hCAFE_F00D});
        vtab.push_back('{6'b010001, 32'h0000_0000, 32'h0,         32'hFFFF_FF7F, 0, K_OK,  4'b0001, 32'h0,         32'h0000_007F});
        vtab.push_back('{6'b010001, 32'h0000_0002, 32'h0,         32'h0095_0000, 0, K_OK,  4'b0100, 32'h0,         32'hFFFF_FF95});
        vtab.push_back('{6'b001001, 32'h0000_0101, 32'h0,         32'h0,        0, K_ERR, 4'b0000, 32'h0,         32'h0});
        vtab.push_back('{6'b000011, 32'h0000_0000, 32'h0,         32'h0,        0, K_ERR, 4'b0000, 32'h0,         32'h0});
        vtab.push_back('{6'b001101, 32'h0000_0000, 32'h0,         32'h0,        0, K_ERR, 4'b0000, 32'h0,         32'h0});
        vtab.push_back('{6'b000101, 32'h0000_0201, 32'h0,         32'h0,        0, K_ERR, 4'b0000, 32'h0,         32'h0});
        vtab.push_back('{6'b001010, 32'h0000_0000, 32'h0,         32'h0,        0, K_NOP, 4'b0000, 32'h0,         32'h0});
        vtab[14].op = 6'b001000;

        #12;
        check_all_zero("reset");
        #1 N_RST = 1'b1;
        @(posedge CLK); #1;

        foreach (vtab[i]) run_vec(vtab[i]);

        // Acknowledge while idle must be ignored.
        MEM_ACK = 1'b1;
        MEM_RDATA = 32'h5555_5555;
        @(posedge CLK); #1;
        MEM_ACK = 1'b0;
        check("idle_ack_busy", 32'(BUSY), 32'h0);
        check("idle_ack_ld_we", 32'(LD_WE), 32'h0);

        // Reset in the middle of a load: everything clears, no late LD_WE.
        LSU_OP = 6'b000001;
        O = 32'h0000_0040;
        @(posedge CLK); #1;
        LSU_OP = 6'h00;
        check("rst_pre_busy", 32'(BUSY), 32'h1);
        @(posedge CLK); #1;
        N_RST = 1'b0;
        #1;
        check_all_zero("midrst");
        MEM_ACK = 1'b1;
        #2;
        MEM_ACK = 1'b0;
        N_RST = 1'b1;
        last_ld = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK); #1;
            check("post_rst_idle", 32'(BUSY | LD_WE | ERR), 32'h0);
        end
        run_vec(vtab[1]);

`ifdef LSU_TIMEOUT_EN
        // No acknowledge: abort after TIMEOUT (4) WAIT cycles.
        LSU_OP = 6'b000001;
        O = 32'h0000_0080;
        err_pending++;
        @(posedge CLK); #1;
        LSU_OP = 6'h00;
        n = 0;
        while (MEM_REQ && n < 20) begin
            n++;
            @(posedge CLK); #1;
        end
        check("timeout_cycles", 32'(n), 32'd4);
        check("timeout_err", 32'(ERR), 32'h1);
        check("timeout_busy", 32'(BUSY), 32'h0);
        check("timeout_ld_we", 32'(LD_WE), 32'h0);
        @(posedge CLK); #1;
        check("timeout_err_clear", 32'(ERR), 32'h0);
        run_vec(vtab[3]);
`endif

        repeat (2) @(posedge CLK);
        #1;
        n = err_pending;
        check("err_all_seen", 32'(n), 32'h0);
        check("bus_q_empty", 32'(bus_q.size()), 32'h0);
        check("ld_q_empty", 32'(ld_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
